// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared definitions for the PC sequencer: decoded instruction
//               classes, FSM state encodings, the PC strobe bundle and a
//               helper that maps an accepted instruction to its strobes.
// Revision    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    // Decoded instruction classes; 5..7 are illegal.
    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_HALT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef struct packed {
        logic hold;
        logic jump;
        logic branch;
        logic ret;
        logic preload;
    } pc_strobe_t;

    localparam pc_strobe_t c_STROBE_NONE = '0;

    // Strobes for one accepted instruction. An all-zero result for anything
    // other than HALT means the instruction cannot execute (illegal class or
    // stack limit) and the FSM will fault out of EXEC.
    function automatic pc_strobe_t decode_strobe(
        input logic [2:0] op,
        input logic       cond,
        input logic       at_max,
        input logic       at_zero
    );
        pc_strobe_t s;
        s = c_STROBE_NONE;
        case (op)
            OP_SEQ: begin
                s.hold = 1'b1;
            end
            OP_JUMP: begin
                s.hold    = 1'b1;
                s.jump    = cond;
                s.preload = cond;
            end
            OP_CALL: begin
                if (!at_max) begin
                    s.hold   = 1'b1;
                    s.jump   = 1'b1;
                    s.branch = 1'b1;
                end
            end
            OP_RET: begin
                if (!at_zero) begin
                    s.hold = 1'b1;
                    s.jump = 1'b1;
                    s.ret  = 1'b1;
                end
            end
            default: s = c_STROBE_NONE;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/call_depth_tracker.sv
`default_nettype none
// ============================================================================
// Module      : call_depth_tracker
// Description : Saturating up/down counter tracking the return-stack depth.
//               It never wraps: inc at the maximum and dec at zero are
//               ignored, as is a simultaneous inc and dec.
// Ports       : clk, rst_n (async active-low), inc, dec,
//               depth[DEPTH_W-1:0], at_max, at_zero
// Revision    : 1.0  initial release
// ============================================================================
module call_depth_tracker #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               at_max,
    output logic               at_zero
);

    logic [DEPTH_W-1:0] r_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (inc && !dec && !at_max) begin
            r_depth <= r_depth + 1'b1;
        end else if (dec && !inc && !at_zero) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign depth   = r_depth;
    assign at_max  = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign at_zero = (r_depth == '0);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Control FSM for the 11-bit program counter and its return
//               stack. Accepts decoded instruction classes while in FETCH
//               (instr_valid && mem_ack), then spends one EXEC cycle driving
//               registered one-cycle PC strobes. Guards CALL/RET against
//               stack overflow/underflow; HALT parks until resume; FAULT is
//               sticky until rst_n.
// Ports       : clk, rst_n (async active-low)
//               instr_valid, instr_ready, op_class[2:0], cond_ok, mem_ack,
//               resume
//               pc_hold, pc_jump, pc_branch, pc_ret, pc_preload
//               depth[DEPTH_W-1:0], halted, fault, timeout
// Config      : PCSEQ_STALL_TIMEOUT_EN - builds a FETCH watchdog that faults
//               after TIMEOUT_CYCLES consecutive cycles without mem_ack.
//               Undefined: FETCH waits forever and timeout is tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int STACK_DEPTH    = 4,
    parameter int DEPTH_W        = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         op_class,
    input  logic               cond_ok,
    input  logic               mem_ack,
    input  logic               resume,
    output logic               pc_hold,
    output logic               pc_jump,
    output logic               pc_branch,
    output logic               pc_ret,
    output logic               pc_preload,
    output logic [DEPTH_W-1:0] depth,
    output logic               halted,
    output logic               fault,
    output logic               timeout
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_op;
    pc_strobe_t   r_strobe;
    pc_strobe_t   w_strobe_nxt;
    logic         w_accept;
    logic         w_inc;
    logic         w_dec;
    logic         w_at_max;
    logic         w_at_zero;
    logic         w_wd_expire;
    logic         w_timeout;

    assign w_accept = (r_state == ST_FETCH) && instr_valid && mem_ack;

    // Depth moves at the end of EXEC, so the limit seen at acceptance is the
    // same one the strobe decision was based on.
    assign w_inc = (r_state == ST_EXEC) && r_strobe.branch;
    assign w_dec = (r_state == ST_EXEC) && r_strobe.ret;

    call_depth_tracker #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_depth (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_inc),
        .dec     (w_dec),
        .depth   (depth),
        .at_max  (w_at_max),
        .at_zero (w_at_zero)
    );

    // ------------------------------------------------------------------
    // State and strobe registers. Strobes are computed at acceptance and
    // registered so they are high exactly during the EXEC cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_strobe <= c_STROBE_NONE;
            r_op     <= OP_SEQ;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_strobe_nxt;
            if (w_accept) begin
                r_op <= op_class;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_strobe_nxt = c_STROBE_NONE;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_accept) begin
                    w_state_nxt  = ST_EXEC;
                    w_strobe_nxt = decode_strobe(op_class, cond_ok, w_at_max, w_at_zero);
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_EXEC: begin
                // Every executable class raises pc_hold; a silent EXEC other
                // than HALT is an illegal class or a stack-limit violation.
                if (r_op == OP_HALT) begin
                    w_state_nxt = ST_HALT;
                end else if (!r_strobe.hold) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FETCH stall watchdog
    // ------------------------------------------------------------------
`ifdef PCSEQ_STALL_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            // mem_ack breaks the run of stalled cycles (and is implied by
            // acceptance), leaving FETCH also restarts the count.
            if ((r_state != ST_FETCH) || mem_ack) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if ((r_state == ST_FETCH) && w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled FETCH cycle.
    assign w_wd_expire = !mem_ack && (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout   = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_wd_expire          = 1'b0;
    assign w_timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_ready = (r_state == ST_FETCH);
    assign halted      = (r_state == ST_HALT);
    assign fault       = (r_state == ST_FAULT);
    assign timeout     = w_timeout;
    assign pc_hold     = r_strobe.hold;
    assign pc_jump     = r_strobe.jump;
    assign pc_branch   = r_strobe.branch;
    assign pc_ret      = r_strobe.ret;
    assign pc_preload  = r_strobe.preload;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: a directed vector
//               table, hand-written corner sequences (stack limits, HALT,
//               FAULT, reset during EXEC, FETCH stall) and a randomized run
//               checked against a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int STACK_DEPTH    = 4;
    localparam int DEPTH_W        = 3;
    localparam int TIMEOUT_CYCLES = 15;

    localparam logic [4:0] S_NONE = 5'b00000;   // {hold,jump,branch,ret,preload}
    localparam logic [4:0] S_SEQ  = 5'b10000;
    localparam logic [4:0] S_JMP  = 5'b11001;
    localparam logic [4:0] S_CALL = 5'b11100;
    localparam logic [4:0] S_RET  = 5'b11010;
    localparam logic [2:0] ST_RUN = 3'b100;      // {instr_ready,halted,fault}
    localparam logic [2:0] ST_HLT = 3'b010;
    localparam logic [2:0] ST_FLT = 3'b001;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               instr_valid = 1'b0;
    logic               mem_ack     = 1'b0;
    logic               cond_ok     = 1'b0;
    logic               resume      = 1'b0;
    logic [2:0]         op_class    = 3'd0;
    logic               instr_ready;
    logic               pc_hold, pc_jump, pc_branch, pc_ret, pc_preload;
    logic [DEPTH_W-1:0] depth;
    logic               halted, fault, timeout;

    pc_sequencer #(
        .STACK_DEPTH    (STACK_DEPTH),
        .DEPTH_W        (DEPTH_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_class    (op_class),
        .cond_ok     (cond_ok),
        .mem_ack     (mem_ack),
        .resume      (resume),
        .pc_hold     (pc_hold),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .pc_ret      (pc_ret),
        .pc_preload  (pc_preload),
        .depth       (depth),
        .halted      (halted),
        .fault       (fault),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int m_depth = 0;

    typedef struct {
        logic [2:0] op;
        logic       cond;
        logic [4:0] exp_s;
        int         exp_d;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [4:0] strobes();
        return {pc_hold, pc_jump, pc_branch, pc_ret, pc_preload};
    endfunction

    function automatic logic [2:0] status();
        return {instr_ready, halted, fault};
    endfunction

    // Instruction-level model: what one accepted instruction does to the PC
    // strobes, the call depth and the sequencer's resting state.
    function automatic void ref_model(input logic [2:0] op, input logic c, input int d,
                                      output logic [4:0] s, output int nd, output logic [2:0] st);
        s  = S_NONE;
        nd = d;
        st = ST_FLT;
        if (op == 3'd0) begin
            s = S_SEQ; st = ST_RUN;
        end else if (op == 3'd1) begin
            s = c ? S_JMP : S_SEQ; st = ST_RUN;
        end else if (op == 3'd2 && d < STACK_DEPTH) begin
            s = S_CALL; nd = d + 1; st = ST_RUN;
        end else if (op == 3'd3 && d > 0) begin
            s = S_RET; nd = d - 1; st = ST_RUN;
        end else if (op == 3'd4) begin
            st = ST_HLT;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0; resume = 1'b0;
        #2;
        check("rst_outputs", 32'({strobes(), instr_ready, halted, fault, timeout}), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_to_fetch", 32'(status()), 32'(ST_RUN));
    endtask

    // Wait for FETCH, optionally stall with only one of valid/ack high, then
    // present one instruction. Returns the EXEC-cycle strobes and the state
    // one cycle later.
    task automatic issue(input logic [2:0] op, input logic c, input int stall,
                         output logic [4:0] s_exec, output int d_after, output logic [7:0] post);
        int k;
        k = 0;
        while (!instr_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!instr_ready) begin
            n_total++;
            $display("FAIL ready_wait: instr_ready=0 after 50 cycles, required 1");
        end
        for (int i = 0; i < stall; i++) begin
            op_class    = op;
            cond_ok     = c;
            instr_valid = 1'($urandom_range(0, 1));
            mem_ack     = ~instr_valid;
            @(posedge clk); #1;
            check("stall_no_accept", 32'({strobes(), status()}), 32'({S_NONE, ST_RUN}));
        end
        op_class = op; cond_ok = c; instr_valid = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ack = 1'b0; cond_ok = ~c; op_class = 3'($urandom);
        s_exec = strobes();
        @(posedge clk); #1;
        d_after = int'(depth);
        post    = {strobes(), status()};
    endtask

    task automatic do_resume();
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_to_fetch", 32'(status()), 32'(ST_RUN));
    endtask

    initial begin
        logic [4:0] s, es;
        logic [7:0] post;
        logic [2:0] op, est;
        logic       c;
        int         d, ed, r;

        vecs[0]  = '{3'd0, 1'b0, S_SEQ,  0};
        vecs[1]  = '{3'd0, 1'b1, S_SEQ,  0};
        vecs[2]  = '{3'd0, 1'b0, S_SEQ,  0};
        vecs[3]  = '{3'd1, 1'b1, S_JMP,  0};
        vecs[4]  = '{3'd1, 1'b0, S_SEQ,  0};
        vecs[5]  = '{3'd2, 1'b0, S_CALL, 1};
        vecs[6]  = '{3'd2, 1'b1, S_CALL, 2};
        vecs[7]  = '{3'd2, 1'b0, S_CALL, 3};
        vecs[8]  = '{3'd2, 1'b0, S_CALL, 4};
        vecs[9]  = '{3'd3, 1'b0, S_RET,  3};
        vecs[10] = '{3'd3, 1'b1, S_RET,  2};
        vecs[11] = '{3'd2, 1'b1, S_CALL, 3};
        vecs[12] = '{3'd3, 1'b0, S_RET,  2};
        vecs[13] = '{3'd3, 1'b0, S_RET,  1};
        vecs[14] = '{3'd3, 1'b0, S_RET,  0};
        vecs[15] = '{3'd1, 1'b1, S_JMP,  0};

        do_reset();

        // Directed table
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].cond, 0, s, d, post);
            check($sformatf("vec%0d_exec", i), 32'(s), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_depth", i), 32'(d), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_post", i), 32'(post), 32'({S_NONE, ST_RUN}));
        end

        // CALL overflow: fifth CALL faults without a strobe, depth held
        for (int i = 0; i < 4; i++) issue(3'd2, 1'b0, 0, s, d, post);
        check("call4_depth", 32'(d), 32'd4);
        issue(3'd2, 1'b0, 0, s, d, post);
        check("call5_exec", 32'(s), 32'(S_NONE));
        check("call5_depth", 32'(d), 32'd4);
        check("call5_post", 32'(post), 32'({S_NONE, ST_FLT}));
        resume = 1'b1; instr_valid = 1'b1; mem_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resume = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
        check("fault_sticky", 32'({strobes(), status()}), 32'({S_NONE, ST_FLT}));
        check("fault_depth", 32'(depth), 32'd4);
        do_reset();

        // RET underflow
        issue(3'd3, 1'b1, 0, s, d, post);
        check("ret0_exec", 32'(s), 32'(S_NONE));
        check("ret0_post", 32'(post), 32'({S_NONE, ST_FLT}));
        do_reset();
        issue(3'd2, 1'b0, 0, s, d, post); check("ccr_d1", 32'(d), 32'd1);
        issue(3'd2, 1'b0, 0, s, d, post); check("ccr_d2", 32'(d), 32'd2);
        issue(3'd3, 1'b0, 0, s, d, post); check("ccr_d3", 32'(d), 32'd1);

        // HALT / resume, depth preserved at 1
        issue(3'd4, 1'b0, 0, s, d, post);
        check("halt_exec", 32'(s), 32'(S_NONE));
        check("halt_post", 32'(post), 32'({S_NONE, ST_HLT}));
        instr_valid = 1'b1; mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0; mem_ack = 1'b0;
        check("halt_parked", 32'({strobes(), status()}), 32'({S_NONE, ST_HLT}));
        do_resume();
        check("resume_depth", 32'(depth), 32'd1);
        resume = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resume = 1'b0;
        check("resume_in_fetch", 32'({strobes(), status()}), 32'({S_NONE, ST_RUN}));
        check("resume_in_fetch_depth", 32'(depth), 32'd1);

        // Illegal class
        issue(3'd6, 1'b1, 0, s, d, post);
        check("illegal_exec", 32'(s), 32'(S_NONE));
        check("illegal_post", 32'(post), 32'({S_NONE, ST_FLT}));
        do_reset();

        // Reset while a CALL strobe is live
        issue(3'd2, 1'b0, 0, s, d, post);
        op_class = 3'd2; instr_valid = 1'b1; mem_ack = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; mem_ack = 1'b0;
        check("midexec_branch", 32'(strobes()), 32'(S_CALL));
        #2 rst_n = 1'b0;
        #1;
        check("midexec_strobe_drop", 32'(strobes()), 32'(S_NONE));
        check("midexec_depth", 32'(depth), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midexec_recover", 32'(status()), 32'(ST_RUN));

        // Randomized run against the reference model
        m_depth = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      op = 3'd0;
            else if (r < 45) op = 3'd1;
            else if (r < 70) op = 3'd2;
            else if (r < 94) op = 3'd3;
            else if (r < 97) op = 3'd4;
            else             op = 3'($urandom_range(5, 7));
            c = 1'($urandom);
            ref_model(op, c, m_depth, es, ed, est);
            issue(op, c, $urandom_range(0, 2), s, d, post);
            check("rnd_exec", 32'(s), 32'(es));
            check("rnd_depth", 32'(d), 32'(ed));
            check("rnd_post", 32'(post), 32'({S_NONE, est}));
            m_depth = ed;
            if (est == ST_HLT) begin
                do_resume();
            end else if (est == ST_FLT) begin
                do_reset();
                m_depth = 0;
            end
        end

        // FETCH stall without mem_ack
        do_reset();
        instr_valid = 1'b1; mem_ack = 1'b0;
`ifdef PCSEQ_STALL_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
        #1;
        check("wd_before_limit", 32'({status(), timeout}), 32'({ST_RUN, 1'b0}));
        @(posedge clk); #1;
        check("wd_fault", 32'({status(), timeout}), 32'({ST_FLT, 1'b1}));
        instr_valid = 1'b0;
        do_reset();
`else
        repeat (100) @(posedge clk);
        #1;
        check("stall_still_waiting", 32'({strobes(), status(), timeout}), 32'({S_NONE, ST_RUN, 1'b0}));
        instr_valid = 1'b0;
        issue(3'd0, 1'b0, 0, s, d, post);
        check("stall_then_seq", 32'(s), 32'(S_SEQ));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
